// File: rtl/coin_frontend_pkg.sv
// Shared definitions for the coin-slot front end: debounce state encoding and defaults.
package coin_frontend_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_t;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int PEND_W_DEF          = 3;

endpackage

// File: rtl/coin_debounce.sv
// One coin button: two-flop synchroniser, debounce FSM and stability counter.
// Emits a single-cycle press pulse per debounced press; holding the button yields one press.
module coin_debounce
    import coin_frontend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    db_state_t        state;
    db_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             press_next;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            state <= state_next;
            cnt   <= cnt_next;
            press <= press_next;
        end
    end

    // The counter only advances while the synchronised level stays at the awaited value.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        press_next = 1'b0;
        case (state)
            IDLE: begin
                if (sync2) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_next = REL_WAIT;
                    cnt_next   = '0;
                end
            end
            REL_WAIT: begin
                if (sync2) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/coin_frontend.sv
// Coin-slot front end: debounced presses are queued per coin type and released
// one token per slow-clock interval, 1-yuan first, never both outputs at once.
module coin_frontend
    import coin_frontend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int PEND_W          = PEND_W_DEF
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic              raw_in1,
    input  logic              raw_in0_5,
    input  logic              slow_tick,
    output logic              in1,
    output logic              in0_5,
    output logic [PEND_W-1:0] pend1,
    output logic [PEND_W-1:0] pend0_5,
    output logic              coin_lost
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic              press1;
    logic              press0_5;
    logic              disp1;
    logic              disp0_5;
    logic [PEND_W-1:0] pend1_next;
    logic [PEND_W-1:0] pend0_5_next;
    logic              lost1;
    logic              lost0_5;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_in1 (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .raw       (raw_in1),
        .press     (press1)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_in0_5 (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .raw       (raw_in0_5),
        .press     (press0_5)
    );

    // Arbitration looks at the queue depths before this cycle's presses land.
    always_comb begin
        disp1   = slow_tick && (pend1 != '0);
        disp0_5 = slow_tick && (pend1 == '0) && (pend0_5 != '0);

        pend1_next = pend1;
        lost1      = 1'b0;
        if (press1 && !disp1) begin
            if (pend1 == PEND_MAX) lost1 = 1'b1;
            else                   pend1_next = pend1 + PEND_W'(1);
        end else if (!press1 && disp1) begin
            pend1_next = pend1 - PEND_W'(1);
        end

        pend0_5_next = pend0_5;
        lost0_5      = 1'b0;
        if (press0_5 && !disp0_5) begin
            if (pend0_5 == PEND_MAX) lost0_5 = 1'b1;
            else                     pend0_5_next = pend0_5 + PEND_W'(1);
        end else if (!press0_5 && disp0_5) begin
            pend0_5_next = pend0_5 - PEND_W'(1);
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            in1       <= 1'b0;
            in0_5     <= 1'b0;
            pend1     <= '0;
            pend0_5   <= '0;
            coin_lost <= 1'b0;
        end else begin
            // Tokens are held for a whole interval so the slow FSM samples each once.
            if (slow_tick) begin
                in1   <= disp1;
                in0_5 <= disp0_5;
            end
            pend1   <= pend1_next;
            pend0_5 <= pend0_5_next;
            if (lost1 || lost0_5) coin_lost <= 1'b1;
        end
    end

endmodule

// File: tb/tb_coin_frontend.sv
// Self-checking bench for coin_frontend: directed scenarios plus randomized
// button/tick traffic, compared each cycle against a run-length reference model.
module tb_coin_frontend;

    localparam int D      = 4;
    localparam int PW     = 3;
    localparam int PMAX   = 7;
    localparam int TICK_P = 20;

    logic          clk_50MHz = 1'b0;
    logic          reset     = 1'b0;
    logic          raw_in1   = 1'b0;
    logic          raw_in0_5 = 1'b0;
    logic          slow_tick = 1'b0;
    logic          in1;
    logic          in0_5;
    logic [PW-1:0] pend1;
    logic [PW-1:0] pend0_5;
    logic          coin_lost;
    logic [8:0]    obs;

    int total = 0;
    int bad   = 0;

    coin_frontend #(.DEBOUNCE_CYCLES(D), .PEND_W(PW)) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .raw_in1   (raw_in1),
        .raw_in0_5 (raw_in0_5),
        .slow_tick (slow_tick),
        .in1       (in1),
        .in0_5     (in0_5),
        .pend1     (pend1),
        .pend0_5   (pend0_5),
        .coin_lost (coin_lost)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    assign obs = {in1, in0_5, pend1, pend0_5, coin_lost};

    // Reference model, index 0 = 1-yuan, 1 = 0.5-yuan.
    // A press is accepted after D+1 consecutive high samples of the button
    // (seen two clocks late) while released; release needs D+1 low samples.
    bit m_hist[2][2];
    int m_run_hi[2];
    int m_run_lo[2];
    bit m_held[2];
    bit m_press[2];
    bit m_out[2];
    int m_pend[2];
    bit m_lost;

    int phase   = 0;
    bit tick_en = 1'b1;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hist[k][0] = 0; m_hist[k][1] = 0;
            m_run_hi[k] = 0; m_run_lo[k] = 0;
            m_held[k] = 0; m_press[k] = 0; m_out[k] = 0; m_pend[k] = 0;
        end
        m_lost = 0;
    endfunction

    function automatic void model_edge(input bit r1, input bit r05, input bit tk);
        bit r[2];
        bit disp[2];
        bit smp;
        int np;
        r[0] = r1;
        r[1] = r05;
        disp[0] = tk && (m_pend[0] != 0);
        disp[1] = tk && (m_pend[0] == 0) && (m_pend[1] != 0);
        if (tk) begin
            m_out[0] = disp[0];
            m_out[1] = disp[1];
        end
        for (int k = 0; k < 2; k++) begin
            np = m_pend[k] + int'(m_press[k]) - int'(disp[k]);
            if (np > PMAX) begin
                np = PMAX;
                m_lost = 1;
            end
            m_pend[k] = np;
        end
        for (int k = 0; k < 2; k++) begin
            smp = m_hist[k][1];
            m_press[k] = 0;
            if (smp) begin m_run_hi[k]++; m_run_lo[k] = 0; end
            else     begin m_run_lo[k]++; m_run_hi[k] = 0; end
            if (!m_held[k] && m_run_hi[k] == D + 1) begin
                m_held[k]  = 1;
                m_press[k] = 1;
            end else if (m_held[k] && m_run_lo[k] == D + 1) begin
                m_held[k] = 0;
            end
            m_hist[k][1] = m_hist[k][0];
            m_hist[k][0] = r[k];
        end
    endfunction

    function automatic logic [8:0] model_vec();
        return {m_out[0], m_out[1], PW'(m_pend[0]), PW'(m_pend[1]), m_lost};
    endfunction

    function automatic bit next_tick();
        bit t;
        t = tick_en && (phase == TICK_P - 1);
        phase = (phase + 1) % TICK_P;
        return t;
    endfunction

    // Drives inputs away from the edge, advances the model at the edge, returns 1 ns later.
    task automatic step(input logic r1, input logic r05, input logic tk);
        raw_in1   = r1;
        raw_in0_5 = r05;
        slow_tick = tk;
        @(posedge clk_50MHz);
        if (!reset) model_reset();
        else        model_edge(r1, r05, tk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        total++; if (in1 !== 1'b0)      begin bad++; $display("FAIL reset_in1 got=%b want=0", in1); end
        total++; if (in0_5 !== 1'b0)    begin bad++; $display("FAIL reset_in0_5 got=%b want=0", in0_5); end
        total++; if (pend1 !== 3'd0)    begin bad++; $display("FAIL reset_pend1 got=%0d want=0", pend1); end
        total++; if (pend0_5 !== 3'd0)  begin bad++; $display("FAIL reset_pend0_5 got=%0d want=0", pend0_5); end
        total++; if (coin_lost !== 1'b0) begin bad++; $display("FAIL reset_coin_lost got=%b want=0", coin_lost); end
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_clean_press();
        int hi_cnt = 0;
        int rises  = 0;
        logic prev = 1'b0;
        phase = 0; tick_en = 1'b1;
        for (int i = 0; i < 75; i++) begin
            step(i < 30, 1'b0, next_tick());
            total++; if (obs !== model_vec()) begin bad++; $display("FAIL clean_cycle%0d got=%b want=%b", i, obs, model_vec()); end
            if (i == 6) begin
                total++; if (pend1 !== 3'd0) begin bad++; $display("FAIL clean_pend1_edge6 got=%0d want=0", pend1); end
            end
            if (i == 7) begin
                total++; if (pend1 !== 3'd1) begin bad++; $display("FAIL clean_pend1_edge7 got=%0d want=1", pend1); end
            end
            if (in1) hi_cnt++;
            if (in1 && !prev) rises++;
            prev = in1;
        end
        total++; if (hi_cnt != 20) begin bad++; $display("FAIL clean_in1_width got=%0d want=20", hi_cnt); end
        total++; if (rises != 1)   begin bad++; $display("FAIL clean_token_count got=%0d want=1", rises); end
        total++; if (pend1 !== 3'd0) begin bad++; $display("FAIL clean_pend1_end got=%0d want=0", pend1); end
    endtask

    task automatic test_bounce();
        logic [3:0] pat = 4'b0101;
        int hi_cnt = 0;
        phase = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, (i < 4) ? pat[i] : 1'b0, next_tick());
            total++; if (obs !== model_vec()) begin bad++; $display("FAIL bounce_cycle%0d got=%b want=%b", i, obs, model_vec()); end
            if (in0_5) hi_cnt++;
        end
        total++; if (hi_cnt != 0)      begin bad++; $display("FAIL bounce_in0_5_high got=%0d want=0", hi_cnt); end
        total++; if (pend0_5 !== 3'd0) begin bad++; $display("FAIL bounce_pend0_5 got=%0d want=0", pend0_5); end
    endtask

    task automatic test_simultaneous();
        phase = 0;
        for (int i = 0; i < 65; i++) begin
            step(i < 10, i < 10, next_tick());
            total++; if (obs !== model_vec()) begin bad++; $display("FAIL simul_cycle%0d got=%b want=%b", i, obs, model_vec()); end
            if (i == 7) begin
                total++; if ({pend1, pend0_5} !== {3'd1, 3'd1}) begin bad++; $display("FAIL simul_pend got=%0d/%0d want=1/1", pend1, pend0_5); end
            end
            if (i == 19) begin
                total++; if ({in1, in0_5} !== 2'b10) begin bad++; $display("FAIL simul_tick1 got=%b want=10", {in1, in0_5}); end
            end
            if (i == 39) begin
                total++; if ({in1, in0_5} !== 2'b01) begin bad++; $display("FAIL simul_tick2 got=%b want=01", {in1, in0_5}); end
            end
            if (i == 59) begin
                total++; if ({in1, in0_5} !== 2'b00) begin bad++; $display("FAIL simul_tick3 got=%b want=00", {in1, in0_5}); end
            end
        end
    endtask

    task automatic test_press_on_tick();
        phase = TICK_P - 1 - 7;
        for (int i = 0; i < 31; i++) begin
            step(i < 10, 1'b0, next_tick());
            total++; if (obs !== model_vec()) begin bad++; $display("FAIL ontick_cycle%0d got=%b want=%b", i, obs, model_vec()); end
            if (i == 7) begin
                total++; if ({in1, pend1} !== {1'b0, 3'd1}) begin bad++; $display("FAIL ontick_same got=%b/%0d want=0/1", in1, pend1); end
            end
            if (i == 27) begin
                total++; if ({in1, pend1} !== {1'b1, 3'd0}) begin bad++; $display("FAIL ontick_next got=%b/%0d want=1/0", in1, pend1); end
            end
        end
    endtask

    task automatic test_saturation();
        tick_en = 1'b0;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 18; i++) begin
                step(i < 8, 1'b0, next_tick());
                total++; if (obs !== model_vec()) begin bad++; $display("FAIL sat_p%0d_cycle%0d got=%b want=%b", p, i, obs, model_vec()); end
            end
            if (p == 6) begin
                total++; if ({pend1, coin_lost} !== {3'd7, 1'b0}) begin bad++; $display("FAIL sat_seventh got=%0d/%b want=7/0", pend1, coin_lost); end
            end
        end
        total++; if (pend1 !== 3'd7)    begin bad++; $display("FAIL sat_pend1 got=%0d want=7", pend1); end
        total++; if (coin_lost !== 1'b1) begin bad++; $display("FAIL sat_coin_lost got=%b want=1", coin_lost); end
        tick_en = 1'b1; phase = 0;
        for (int i = 0; i < 150; i++) begin
            step(1'b0, 1'b0, next_tick());
            total++; if (obs !== model_vec()) begin bad++; $display("FAIL drain_cycle%0d got=%b want=%b", i, obs, model_vec()); end
        end
        total++; if ({pend1, coin_lost} !== {3'd0, 1'b1}) begin bad++; $display("FAIL drain_end got=%0d/%b want=0/1", pend1, coin_lost); end
    endtask

    task automatic test_async_reset();
        tick_en = 1'b0;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 18; i++) step(i < 8, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        total++; if ({in1, pend1} !== {1'b1, 3'd3}) begin bad++; $display("FAIL arst_setup got=%b/%0d want=1/3", in1, pend1); end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        total++; if (in1 !== 1'b0)       begin bad++; $display("FAIL arst_in1 got=%b want=0", in1); end
        total++; if (pend1 !== 3'd0)     begin bad++; $display("FAIL arst_pend1 got=%0d want=0", pend1); end
        total++; if (coin_lost !== 1'b0) begin bad++; $display("FAIL arst_coin_lost got=%b want=0", coin_lost); end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(i < 8, 1'b0, 1'b0);
            total++; if (obs !== model_vec()) begin bad++; $display("FAIL arst_after_cycle%0d got=%b want=%b", i, obs, model_vec()); end
            if (i == 6) begin
                total++; if (pend1 !== 3'd0) begin bad++; $display("FAIL arst_latency6 got=%0d want=0", pend1); end
            end
            if (i == 7) begin
                total++; if (pend1 !== 3'd1) begin bad++; $display("FAIL arst_latency7 got=%0d want=1", pend1); end
            end
        end
    endtask

    task automatic test_random();
        int   left[2];
        logic lvl[2];
        left[0] = 0; left[1] = 0; lvl[0] = 1'b0; lvl[1] = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (left[k] == 0) begin
                    lvl[k]  = 1'($urandom_range(0, 1));
                    left[k] = $urandom_range(1, 14);
                end
                left[k]--;
            end
            step(lvl[0], lvl[1], $urandom_range(0, 9) == 0);
            total++; if (obs !== model_vec()) begin bad++; $display("FAIL rand_cycle%0d got=%b want=%b", i, obs, model_vec()); end
            total++; if (in1 && in0_5) begin bad++; $display("FAIL rand_both_high cycle%0d got=11 want=not both", i); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_press_on_tick();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
